// File: rtl/game_event_ctrl.sv
// -----------------------------------------------------------------------------
// game_event_ctrl
//   Folds the per-pixel event flags from the pixel priority mux into per-frame
//   events. Runs the crash/recover FSM, keeps a saturating score and issues a
//   req/ack sound request to the audio block.
//
//   Optional build macro: OFFROAD_DEBOUNCE_EN. When it is defined, a crash
//   requires offroad on two consecutive evaluated frames.
//
// Ports
//   clk           in   1        system clock
//   resetN        in   1        asynchronous active-low reset
//   startOfFrame  in   1        1-cycle pulse at start of each frame
//   game_states   in   5        [0]=bonus overlap, [1]=offroad, [4:2] unused
//   game_restart  in   1        synchronous clear of everything
//   sound_ack     in   1        audio block accepted the current request
//   score         out  SCORE_W  accumulated score, saturating
//   bonus_pulse   out  1        1-cycle pulse per awarded bonus
//   crash_active  out  1        high while in CRASH
//   blink         out  1        high in RECOVER on odd frames
//   sound_req     out  1        sound request, held until acked
//   sound_id      out  2        0=none, 1=bonus, 2=crash
// -----------------------------------------------------------------------------
module game_event_ctrl #(
  parameter int unsigned SCORE_W        = 16,
  parameter int unsigned BONUS_POINTS   = 100,
  parameter int unsigned CRASH_FRAMES   = 45,
  parameter int unsigned RECOVER_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [4:0]         game_states,
  input  logic               game_restart,
  input  logic               sound_ack,
  output logic [SCORE_W-1:0] score,
  output logic               bonus_pulse,
  output logic               crash_active,
  output logic               blink,
  output logic               sound_req,
  output logic [1:0]         sound_id
);

  localparam int unsigned MAX_FRAMES = (CRASH_FRAMES > RECOVER_FRAMES) ? CRASH_FRAMES : RECOVER_FRAMES;
  localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int unsigned SUM_W      = SCORE_W + 32;

  localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
  localparam logic [CNT_W-1:0]   CRASH_LAST   = CNT_W'(CRASH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   RECOVER_LAST = CNT_W'(RECOVER_FRAMES - 1);

  localparam logic [1:0] SND_NONE  = 2'd0;
  localparam logic [1:0] SND_BONUS = 2'd1;
  localparam logic [1:0] SND_CRASH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CRASH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  // Frame accumulation / event pipeline
  logic bon_acc;
  logic off_acc;
  logic frm_bon;
  logic frm_off;
  logic prev_bon;
  logic sof_d;
  logic evt_valid;
  logic evt_bon;
  logic evt_off;
  logic off_trig;

  // FSM and output state
  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               crash_start;
  logic               bonus_award;
  logic [SCORE_W-1:0] score_nxt;
  logic [SUM_W-1:0]   score_sum;
  logic               bonus_pulse_nxt;
  logic               crash_active_nxt;
  logic               blink_nxt;
  logic               sound_req_nxt;
  logic [1:0]         sound_id_nxt;
  logic [1:0]         snd_defer;
  logic [1:0]         snd_defer_nxt;
  logic [1:0]         evt_id;
  logic [1:0]         inc_id;

  // Upper flag bits are owned by other consumers of the mux output.
  logic unused_flags;
  assign unused_flags = ^game_states[4:2];

`ifdef OFFROAD_DEBOUNCE_EN
  // Offroad seen on the previous evaluated frame.
  logic off_hist;
  assign off_trig = frm_off & off_hist;
`else
  assign off_trig = frm_off;
`endif

  // Per-frame accumulation; the SOF-cycle flag belongs to the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bon_acc   <= 1'b0;
      off_acc   <= 1'b0;
      frm_bon   <= 1'b0;
      frm_off   <= 1'b0;
      prev_bon  <= 1'b0;
      sof_d     <= 1'b0;
      evt_valid <= 1'b0;
      evt_bon   <= 1'b0;
      evt_off   <= 1'b0;
`ifdef OFFROAD_DEBOUNCE_EN
      off_hist  <= 1'b0;
`endif
    end else if (game_restart) begin
      bon_acc   <= 1'b0;
      off_acc   <= 1'b0;
      frm_bon   <= 1'b0;
      frm_off   <= 1'b0;
      prev_bon  <= 1'b0;
      sof_d     <= 1'b0;
      evt_valid <= 1'b0;
      evt_bon   <= 1'b0;
      evt_off   <= 1'b0;
`ifdef OFFROAD_DEBOUNCE_EN
      off_hist  <= 1'b0;
`endif
    end else begin
      if (startOfFrame) begin
        frm_bon  <= bon_acc;
        frm_off  <= off_acc;
        prev_bon <= frm_bon;
        bon_acc  <= game_states[0];
        off_acc  <= game_states[1];
      end else begin
        bon_acc  <= bon_acc | game_states[0];
        off_acc  <= off_acc | game_states[1];
      end
      sof_d     <= startOfFrame;
      evt_valid <= sof_d;
      // Evaluate the frame one cycle after SOF; bonus counts on a rising edge only.
      if (sof_d) begin
        evt_bon  <= frm_bon & ~prev_bon;
        evt_off  <= off_trig;
`ifdef OFFROAD_DEBOUNCE_EN
        off_hist <= frm_off;
`endif
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      score        <= '0;
      bonus_pulse  <= 1'b0;
      crash_active <= 1'b0;
      blink        <= 1'b0;
      sound_req    <= 1'b0;
      sound_id     <= SND_NONE;
      snd_defer    <= SND_NONE;
    end else if (game_restart) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      score        <= '0;
      bonus_pulse  <= 1'b0;
      crash_active <= 1'b0;
      blink        <= 1'b0;
      sound_req    <= 1'b0;
      sound_id     <= SND_NONE;
      snd_defer    <= SND_NONE;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      score        <= score_nxt;
      bonus_pulse  <= bonus_pulse_nxt;
      crash_active <= crash_active_nxt;
      blink        <= blink_nxt;
      sound_req    <= sound_req_nxt;
      sound_id     <= sound_id_nxt;
      snd_defer    <= snd_defer_nxt;
    end
  end

  // Next state: transitions only on a frame evaluation.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    crash_start = 1'b0;
    bonus_award = 1'b0;
    if (evt_valid) begin
      case (state)
        ST_IDLE: begin
          // Crash wins over a bonus in the same frame.
          if (evt_off) begin
            state_nxt   = ST_CRASH;
            cnt_nxt     = '0;
            crash_start = 1'b1;
          end else begin
            bonus_award = evt_bon;
          end
        end
        ST_CRASH: begin
          if (cnt == CRASH_LAST) begin
            state_nxt = ST_RECOVER;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RECOVER: begin
          bonus_award = evt_bon;
          if (cnt == RECOVER_LAST) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Wide sum so the saturation compare never wraps.
  assign score_sum = SUM_W'(score) + SUM_W'(BONUS_POINTS);

  // Output values for the next cycle.
  always_comb begin
    score_nxt        = score;
    bonus_pulse_nxt  = bonus_award;
    crash_active_nxt = (state_nxt == ST_CRASH);
    blink_nxt        = (state_nxt == ST_RECOVER) & cnt_nxt[0];
    sound_req_nxt    = sound_req;
    sound_id_nxt     = sound_id;
    snd_defer_nxt    = SND_NONE;
    evt_id           = SND_NONE;
    inc_id           = SND_NONE;

    if (bonus_award) begin
      score_nxt = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : SCORE_W'(score_sum);
    end

    if (crash_start) begin
      evt_id = SND_CRASH;
    end else if (bonus_award) begin
      evt_id = SND_BONUS;
    end

    // Merge a fresh event with one deferred by last cycle's ack; crash dominates.
    if (evt_id == SND_CRASH || snd_defer == SND_CRASH) begin
      inc_id = SND_CRASH;
    end else if (evt_id == SND_BONUS || snd_defer == SND_BONUS) begin
      inc_id = SND_BONUS;
    end

    if (sound_req && sound_ack) begin
      // Ack retires the old request; a coincident event launches next cycle.
      sound_req_nxt = 1'b0;
      sound_id_nxt  = SND_NONE;
      snd_defer_nxt = inc_id;
    end else if (sound_req) begin
      // Pending: crash upgrades the id, a bonus is dropped.
      if (inc_id == SND_CRASH) begin
        sound_id_nxt = SND_CRASH;
      end
    end else if (inc_id != SND_NONE) begin
      sound_req_nxt = 1'b1;
      sound_id_nxt  = inc_id;
    end
  end

endmodule

// File: tb/tb_game_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_event_ctrl
//   Scoreboard bench for game_event_ctrl (SCORE_W=8 so saturation is reachable).
//   A frame-level reference model predicts score / crash / blink / pulse after
//   every frame evaluation and the sound id of every request; a monitor and an
//   auto-acking sound responder pop and compare.
// -----------------------------------------------------------------------------
module tb_game_event_ctrl;

  localparam int SCORE_W      = 8;
  localparam int BONUS_POINTS = 100;
  localparam int CF           = 45;
  localparam int RF           = 60;
  localparam int SMAX         = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic [4:0]         game_states;
  logic               game_restart;
  logic               ack_auto;
  logic               ack_man;
  logic               sound_ack;
  logic [SCORE_W-1:0] score;
  logic               bonus_pulse;
  logic               crash_active;
  logic               blink;
  logic               sound_req;
  logic [1:0]         sound_id;

  assign sound_ack = ack_auto | ack_man;

  always #5 clk = ~clk;

  game_event_ctrl #(
    .SCORE_W        (SCORE_W),
    .BONUS_POINTS   (BONUS_POINTS),
    .CRASH_FRAMES   (CF),
    .RECOVER_FRAMES (RF)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .game_states  (game_states),
    .game_restart (game_restart),
    .sound_ack    (sound_ack),
    .score        (score),
    .bonus_pulse  (bonus_pulse),
    .crash_active (crash_active),
    .blink        (blink),
    .sound_req    (sound_req),
    .sound_id     (sound_id)
  );

  typedef struct packed {
    logic [SCORE_W-1:0] score;
    logic               crash;
    logic               blink;
    logic               pulse;
  } frm_exp_t;

  frm_exp_t   frm_q[$];
  logic [1:0] snd_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (frame-level)
  int m_score;
  int m_cs;      // evaluation index of the latest crash start, -1 if none
  int m_k = 0;   // evaluation index
  bit m_prev_b;
  bit m_prev_o;
  bit m_acc_b;
  bit m_acc_o;
  bit acker_en;

  logic       snap_req [0:63];
  logic [1:0] snap_id  [0:63];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_score  = 0;
    m_cs     = -1;
    m_prev_b = 1'b0;
    m_prev_o = 1'b0;
    m_acc_b  = 1'b0;
    m_acc_o  = 1'b0;
  endtask

  // Evaluate one completed frame; crash occupies evaluations cs+1..cs+CF,
  // recover cs+CF+1..cs+CF+RF, idle otherwise.
  task automatic model_eval(input bit fb, input bit fo);
    int       d;
    bit       in_crash;
    bit       in_rec;
    bit       bev;
    bit       oev;
    frm_exp_t e;
    d        = (m_cs >= 0) ? (m_k - m_cs) : 1000000;
    in_crash = (d >= 1) && (d <= CF);
    in_rec   = (d >= CF + 1) && (d <= CF + RF);
    bev      = fb & ~m_prev_b;
    m_prev_b = fb;
`ifdef OFFROAD_DEBOUNCE_EN
    oev      = fo & m_prev_o;
`else
    oev      = fo;
`endif
    m_prev_o = fo;
    e.pulse  = 1'b0;
    if (!in_crash && !in_rec && oev) begin
      m_cs = m_k;
      if (acker_en) snd_q.push_back(2'd2);
    end else if (!in_crash && bev) begin
      m_score = (m_score + BONUS_POINTS > SMAX) ? SMAX : m_score + BONUS_POINTS;
      e.pulse = 1'b1;
      if (acker_en) snd_q.push_back(2'd1);
    end
    d       = (m_cs >= 0) ? (m_k - m_cs) : 1000000;
    e.crash = (d >= 0) && (d <= CF - 1);
    e.blink = (d >= CF) && (d <= CF + RF - 1) && (((d - CF) % 2) == 1);
    e.score = SCORE_W'(m_score);
    frm_q.push_back(e);
    m_k++;
  endtask

  // One frame: SOF on cycle 0, flags with pb/po percent per pixel, optional ack.
  task automatic drive_frame(input int len, input int pb, input int po, input int ack_at);
    logic [4:0] gs;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      snap_req[i] = sound_req;
      snap_id[i]  = sound_id;
      gs    = 5'($urandom);
      gs[0] = ($urandom_range(0, 99) < pb);
      gs[1] = ($urandom_range(0, 99) < po);
      if (i == 0) begin
        model_eval(m_acc_b, m_acc_o);
        m_acc_b = gs[0];
        m_acc_o = gs[1];
      end else begin
        m_acc_b = m_acc_b | gs[0];
        m_acc_o = m_acc_o | gs[1];
      end
      startOfFrame = (i == 0);
      game_states  = gs;
      ack_man      = (i == ack_at);
    end
    @(negedge clk);
    snap_req[len] = sound_req;
    snap_id[len]  = sound_id;
    startOfFrame  = 1'b0;
    game_states   = 5'd0;
    ack_man       = 1'b0;
  endtask

  task automatic restart_pulse();
    @(negedge clk);
    game_restart = 1'b1;
    @(negedge clk);
    game_restart = 1'b0;
    model_reset();
  endtask

  // Frame monitor: outputs settle two edges after the edge that samples SOF.
  logic [2:0] sof_pipe = 3'b000;
  always @(posedge clk) sof_pipe <= {sof_pipe[1:0], startOfFrame};

  always @(negedge clk) begin : frame_mon
    frm_exp_t e;
    if (sof_pipe[2] === 1'b1) begin
      if (frm_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame_queue_empty: got evaluation with no expectation (t=%0t)", $time);
      end else begin
        e = frm_q.pop_front();
        check("frame_score", 32'(score), 32'(e.score));
        check("frame_crash_active", 32'(crash_active), 32'(e.crash));
        check("frame_blink", 32'(blink), 32'(e.blink));
        check("frame_bonus_pulse", 32'(bonus_pulse), 32'(e.pulse));
      end
    end
  end

  // Sound responder: acks after a random delay and checks the acked id.
  initial begin : acker
    int         dly;
    logic [1:0] id;
    logic [1:0] exp_id;
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (acker_en && sound_req === 1'b1) begin
        dly = $urandom_range(0, 5);
        repeat (dly) @(negedge clk);
        id       = sound_id;
        ack_auto = 1'b1;
        @(negedge clk);
        ack_auto = 1'b0;
        check("ack_clears_req", 32'(sound_req), 32'd0);
        check("ack_clears_id", 32'(sound_id), 32'd0);
        if (snd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sound_unexpected: got id %0d expected no request", id);
        end else begin
          exp_id = snd_q.pop_front();
          check("sound_id_at_ack", 32'(id), 32'(exp_id));
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int len;
    int pb;
    int po;
    resetN       = 1'b0;
    startOfFrame = 1'b0;
    game_states  = 5'd0;
    game_restart = 1'b0;
    ack_man      = 1'b0;
    acker_en     = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset_score", 32'(score), 32'd0);
    check("reset_bonus_pulse", 32'(bonus_pulse), 32'd0);
    check("reset_crash_active", 32'(crash_active), 32'd0);
    check("reset_blink", 32'(blink), 32'd0);
    check("reset_sound_req", 32'(sound_req), 32'd0);
    check("reset_sound_id", 32'(sound_id), 32'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Continuous overlap across frames awards exactly once.
    acker_en = 1'b1;
    drive_frame(10, 100, 0, -1);
    repeat (3) drive_frame(20, 100, 0, -1);
    drive_frame(20, 0, 0, -1);
    drive_frame(20, 0, 0, -1);
    check("overlap_single_award", 32'(score), 32'd100);

    // Pending bonus request upgraded to crash.
    acker_en = 1'b0;
    restart_pulse();
    drive_frame(12, 100, 0, -1);
    drive_frame(12, 0, 100, -1);
    check("pending_bonus_req", 32'(snap_req[3]), 32'd1);
    check("pending_bonus_id", 32'(snap_id[3]), 32'd1);
`ifdef OFFROAD_DEBOUNCE_EN
    drive_frame(12, 0, 100, -1);
`endif
    drive_frame(12, 0, 0, -1);
    check("upgrade_req_held", 32'(snap_req[3]), 32'd1);
    check("upgrade_id", 32'(snap_id[3]), 32'd2);

    // Restart while crashed.
    check("crash_before_restart", 32'(crash_active), 32'd1);
    restart_pulse();
    check("restart_score", 32'(score), 32'd0);
    check("restart_crash_active", 32'(crash_active), 32'd0);
    check("restart_sound_req", 32'(sound_req), 32'd0);
    check("restart_sound_id", 32'(sound_id), 32'd0);

    // Crash event on the same edge as the ack of a pending bonus.
    drive_frame(12, 100, 0, -1);
    drive_frame(12, 0, 100, -1);
`ifdef OFFROAD_DEBOUNCE_EN
    drive_frame(12, 0, 100, -1);
`endif
    drive_frame(12, 0, 0, 2);
    check("same_cycle_ack_req", 32'(snap_req[3]), 32'd0);
    check("same_cycle_ack_id", 32'(snap_id[3]), 32'd0);
    check("deferred_req", 32'(snap_req[4]), 32'd1);
    check("deferred_id", 32'(snap_id[4]), 32'd2);
    drive_frame(12, 0, 0, 5);
    check("held_until_ack_req", 32'(snap_req[5]), 32'd1);
    check("held_until_ack_id", 32'(snap_id[5]), 32'd2);
    check("manual_ack_req", 32'(snap_req[6]), 32'd0);
    check("manual_ack_id", 32'(snap_id[6]), 32'd0);
    check("ack_when_idle_ignored", 32'(sound_req), 32'd0);

    // Saturation at 2^SCORE_W-1.
    restart_pulse();
    acker_en = 1'b1;
    repeat (3) begin
      drive_frame(16, 100, 0, -1);
      drive_frame(16, 0, 0, -1);
    end
    check("score_saturated", 32'(score), 32'(SMAX));
    drive_frame(16, 0, 0, -1);

    // Randomized frames: bonus, offroad, crash/recover, ignored events.
    restart_pulse();
    for (int f = 0; f < 400; f++) begin
      len = $urandom_range(16, 24);
      pb  = ($urandom_range(0, 1) == 1) ? 30 : 0;
      po  = ($urandom_range(0, 99) < 12) ? 20 : 0;
      drive_frame(len, pb, po, -1);
    end
    drive_frame(20, 0, 0, -1);
    repeat (10) @(negedge clk);
    check("frame_queue_drained", 32'(frm_q.size()), 32'd0);
    check("sound_queue_drained", 32'(snd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
